// File: rtl/alu_wb_queue_pkg.sv
// Shared CPU package: datapath widths, ALU op encoding and the writeback entry record.
package alu_wb_queue_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_WORD_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_queue.sv
// Circular FIFO of ALU results feeding the register-file write port, with
// newest-wins forwarding lookup over the occupied entries.
module alu_wb_queue
  import alu_wb_queue_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WORD_W = DEF_WORD_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_z,
  input  logic [REG_W-1:0]           in_rd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [REG_W-1:0]           wb_rd,
  output logic [WORD_W-1:0]          wb_data,
  input  logic [REG_W-1:0]           fwd_rd,
  output logic                       fwd_hit,
  output logic [WORD_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [REG_W-1:0]  rd_mem_q   [DEPTH];
  logic [REG_W-1:0]  rd_mem_d   [DEPTH];
  logic [WORD_W-1:0] data_mem_q [DEPTH];
  logic [WORD_W-1:0] data_mem_d [DEPTH];
  logic              push, pop;

  always_comb begin
    in_ready   = count_q < (AW+1)'(DEPTH);
    wb_valid   = count_q != '0;
    // r0 writes complete the handshake but never occupy a slot
    push       = in_valid && in_ready && (in_rd != '0);
    pop        = wb_valid && wb_ready;
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wptr_q]   = in_rd;
      data_mem_d[wptr_q] = in_z;
    end
    wb_rd   = wb_valid ? rd_mem_q[rptr_q]   : '0;
    wb_data = wb_valid ? data_mem_q[rptr_q] : '0;
  end

  // Walk from newest (wptr-1) to oldest; first occupied match wins.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wptr_q - AW'(i + 1);
      if (!fwd_hit && (fwd_rd != '0) && ((AW+1)'(i) < count_q) &&
          (rd_mem_q[idx] == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy gating hides stale contents.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed bench for alu_wb_queue: per-cycle vector table plus wrap and async-reset sequences.
module tb_alu_wb_queue;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_z;
  logic [3:0]  in_rd;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [3:0]  fwd_rd;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_wb_queue #(.DEPTH(4), .WORD_W(16), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] z;
    logic [3:0]  rd;
    logic        wr;
    logic [3:0]  frd;
    logic        e_ir;
    logic        e_wv;
    logic [3:0]  e_rd;
    logic [15:0] e_data;
    logic        e_hit;
    logic [15:0] e_fd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [15:0] z, logic [3:0] rd, logic wr,
                              logic [3:0] frd, logic e_ir, logic e_wv, logic [3:0] e_rd,
                              logic [15:0] e_data, logic e_hit, logic [15:0] e_fd,
                              logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.z = z; v.rd = rd; v.wr = wr; v.frd = frd;
    v.e_ir = e_ir; v.e_wv = e_wv; v.e_rd = e_rd; v.e_data = e_data;
    v.e_hit = e_hit; v.e_fd = e_fd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] z, input logic [3:0] rd,
                       input logic wr, input logic [3:0] frd);
    in_valid = iv; in_z = z; in_rd = rd; wb_ready = wr; fwd_rd = frd;
  endtask

  int next_push, next_exp;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0);

    // Inputs applied at negedge take effect at the following posedge; the
    // expected columns describe outputs during that cycle, before the edge.
    //              iv  z        rd  wr frd  ir wv rd  data     hit fd       cnt
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h1234, 3, 1, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 3,  1, 1, 3, 16'h1234, 1, 16'h1234, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 3,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'hFFFF, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h0001, 5, 0, 5,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h0002, 5, 0, 5,  1, 1, 5, 16'h0001, 1, 16'h0001, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 5,  1, 1, 5, 16'h0001, 1, 16'h0002, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 5,  1, 1, 5, 16'h0001, 1, 16'h0002, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 5,  1, 1, 5, 16'h0002, 1, 16'h0002, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 5,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h0A01, 1, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h0A02, 2, 0, 0,  1, 1, 1, 16'h0A01, 0, 16'h0000, 1));
    vecs.push_back(mk(1, 16'h0A03, 3, 0, 0,  1, 1, 1, 16'h0A01, 0, 16'h0000, 2));
    vecs.push_back(mk(1, 16'h0A04, 4, 0, 0,  1, 1, 1, 16'h0A01, 0, 16'h0000, 3));
    vecs.push_back(mk(1, 16'hBEEF, 6, 0, 2,  0, 1, 1, 16'h0A01, 1, 16'h0A02, 4));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 4,  0, 1, 1, 16'h0A01, 1, 16'h0A04, 4));
    vecs.push_back(mk(1, 16'h7777, 7, 1, 0,  0, 1, 1, 16'h0A01, 0, 16'h0000, 4));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 7,  1, 1, 2, 16'h0A02, 0, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0,  1, 1, 3, 16'h0A03, 0, 16'h0000, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0,  1, 1, 4, 16'h0A04, 0, 16'h0000, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0));

    // reset state, with a lookup that must not hit on stale storage
    fwd_rd = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_rd",    32'(wb_rd),    32'd0);
    chk("rst wb_data",  32'(wb_data),  32'd0);
    chk("rst fwd_hit",  32'(fwd_hit),  32'd0);
    chk("rst count",    32'(count),    32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].z, vecs[i].rd, vecs[i].wr, vecs[i].frd);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wv));
      chk($sformatf("v%0d wb_rd", i),    32'(wb_rd),    32'(vecs[i].e_rd));
      chk($sformatf("v%0d wb_data", i),  32'(wb_data),  32'(vecs[i].e_data));
      chk($sformatf("v%0d fwd_hit", i),  32'(fwd_hit),  32'(vecs[i].e_hit));
      chk($sformatf("v%0d fwd_data", i), 32'(fwd_data), 32'(vecs[i].e_fd));
      chk($sformatf("v%0d count", i),    32'(count),    32'(vecs[i].e_cnt));
    end

    // Stream rd 1..8 through the 4-deep queue: fill first, then drain while pushing.
    next_push = 1;
    next_exp  = 1;
    for (int cyc = 0; cyc < 60 && next_exp <= 8; cyc++) begin
      @(negedge clk);
      drive(next_push <= 8, 16'hC000 | 16'(next_push), 4'(next_push), next_push > 4, 4'd0);
      #1;
      if (wb_valid && wb_ready) begin
        chk("wrap wb_rd",   32'(wb_rd),   32'(next_exp));
        chk("wrap wb_data", 32'(wb_data), 32'(16'hC000 | 16'(next_exp)));
        next_exp++;
      end
      if (in_valid && in_ready) next_push++;
    end
    chk("wrap popped", 32'(next_exp), 32'd9);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b1, 4'h0);
    #1;
    chk("wrap empty wb_valid", 32'(wb_valid), 32'd0);
    chk("wrap empty count",    32'(count),    32'd0);

    // Async reset with three entries queued, asserted mid-cycle.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1'b1, 16'hD000 | 16'(k), 4'(k), 1'b0, 4'h0);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'd2);
    #1;
    chk("pre-rst count",   32'(count),   32'd3);
    chk("pre-rst fwd_hit", 32'(fwd_hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst count",    32'(count),    32'd0);
    chk("async rst wb_valid", 32'(wb_valid), 32'd0);
    chk("async rst wb_rd",    32'(wb_rd),    32'd0);
    chk("async rst wb_data",  32'(wb_data),  32'd0);
    chk("async rst fwd_hit",  32'(fwd_hit),  32'd0);
    chk("async rst fwd_data", 32'(fwd_data), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk); #1;
    chk("post-rst wb_valid", 32'(wb_valid), 32'd0);
    chk("post-rst count",    32'(count),    32'd0);
    chk("post-rst fwd_hit",  32'(fwd_hit),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_queue.md
ALU_WB_QUEUE -- requirements
Module: alu_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered ALU results (power of two, >=2).
REQ-002 Parameter WORD_W, default 16, meaning data width, equal to the `WORD width used by alu.
REQ-003 Parameter REG_W, default 4, meaning destination register index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  an ALU result is presented this cycle.
REQ-007 in_ready  output  1  queue can accept a result this cycle.
REQ-008 in_z  input  WORD_W  ALU result (alu z output).
REQ-009 in_rd  input  REG_W  destination register of the result.
REQ-010 wb_valid  output  1  head entry presented to register-file write port.
REQ-011 wb_ready  input  1  register file accepts the write this cycle.
REQ-012 wb_rd  output  REG_W  head destination register.
REQ-013 wb_data  output  WORD_W  head result value.
REQ-014 fwd_rd  input  REG_W  forwarding lookup register index.
REQ-015 fwd_hit  output  1  a queued entry targets fwd_rd.
REQ-016 fwd_data  output  WORD_W  newest queued value for fwd_rd.
REQ-017 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Block SHALL be a circular FIFO of {rd, data} entries, downstream of alu, feeding register-file writeback.
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when wb_valid && wb_ready.
REQ-020 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on wb_ready.
REQ-021 A push with in_rd == 0 SHALL be accepted (handshake completes) but SHALL NOT allocate an entry (r0 discard).
REQ-022 wb_valid SHALL equal (count != 0); wb_rd/wb_data SHALL show the head entry, and 0 when empty.
REQ-023 Push-to-wb latency SHALL be 1 cycle: an entry pushed at edge N is visible on wb_* after edge N when queue was empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; when full, in_ready=0 so no push occurs even if a pop happens that cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH without gap or duplication.
REQ-026 wb_* outputs SHALL remain stable while wb_valid && !wb_ready.
REQ-027 Forwarding SHALL be combinational over occupied entries only; on multiple matches the most recently pushed entry SHALL win.
REQ-028 fwd_rd == 0 or no match SHALL give fwd_hit=0, fwd_data=0; same-cycle incoming in_z SHALL NOT be forwarded.
REQ-029 An entry popped this cycle SHALL still be visible to forwarding during that cycle.

Reset
REQ-030 rst_n low SHALL asynchronously clear pointers and count to 0, forcing wb_valid=0, wb_rd=0, wb_data=0, fwd_hit=0, fwd_data=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; no write SHALL be presented after release until a new push.
REQ-032 Entry storage contents need not be reset; occupancy gating alone SHALL hide stale data.

Structure
REQ-033 WORD_W, REG_W, DEPTH defaults and the entry record type SHALL live in the shared CPU package alongside the ALUop constants.
REQ-034 No sub-module; the forwarding priority search SHALL be a single combinational loop from newest to oldest entry.

Verification
REQ-035 Push rd=3,z=0x1234 with wb_ready=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x1234; following cycle count=0.
REQ-036 wb_ready=0, push 4 results rd=1..4 -> count=4, in_ready=0; 5th in_valid not accepted; then wb_ready=1 drains rd 1,2,3,4 in order.
REQ-037 Push rd=5 z=0x0001 then rd=5 z=0x0002, fwd_rd=5 -> fwd_hit=1, fwd_data=0x0002; after both popped fwd_hit=0.
REQ-038 Push rd=0 z=0xFFFF -> handshake completes, count stays 0, wb_valid stays 0.
REQ-039 Full queue, wb_ready=1 for 8 cycles with continuous pushes rd=1..8 -> pointers wrap, outputs rd 1..8 in order, no loss or duplication.
REQ-040 Assert rst_n=0 asynchronously with 3 entries queued -> count=0, wb_valid=0 immediately, before next clk edge.
